// File: rtl/rv32_pipeline_pkg.sv
// Shared definitions for the RV32IM pipeline front end: word size,
// reset/bubble constants, the fetch state encoding and a small address helper.
package rv32_pipeline_pkg;

  localparam int XLEN = 32;

  // PC loaded on reset
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  // ADDI x0,x0,0: the bubble placed in IF/ID on flushes and empty slots
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  // START: one idle cycle after reset
  // FETCH: request the word at PC
  // HOLD : a word was accepted under stall and is parked in the hold buffer
  // DRAIN: a redirect arrived mid-access; finish it and throw the word away
  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // Instructions are word aligned, so redirect targets drop their low two bits
  function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Flush beats hold, hold beats load, and a cycle
// with none of them leaves a bubble (NOP, not valid) with the PC fields kept.
module if_id_register
  import rv32_pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pcPlus4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pcPlus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pcPlus4_q;
  logic            valid_q;

  // Update the decode-stage slot according to flush/hold/load priority
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= '0;
      pcPlus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (flush_i) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (hold_i) begin
      instr_q   <= instr_q;
      pc_q      <= pc_q;
      pcPlus4_q <= pcPlus4_q;
      valid_q   <= valid_q;
    end else if (load_i) begin
      instr_q   <= instr_i;
      pc_q      <= pc_i;
      pcPlus4_q <= pcPlus4_i;
      valid_q   <= 1'b1;
    end else begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pcPlus4_o = pcPlus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the READ/BUSYWAIT handshake with
// instruction memory, parks words accepted during a stall, drains accesses
// interrupted by a redirect, and feeds the IF/ID register.
module instruction_fetch_unit
  import rv32_pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            STALL,
  input  logic            BRANCH_TAKEN,
  input  logic [XLEN-1:0] BRANCH_TARGET,
  output logic [XLEN-1:0] IMEM_ADDR,
  output logic            IMEM_READ,
  input  logic            IMEM_BUSYWAIT,
  input  logic [XLEN-1:0] IMEM_READDATA,
  output logic [XLEN-1:0] INSTRUCTION,
  output logic [XLEN-1:0] PC_OUT,
  output logic [XLEN-1:0] PC_PLUS4_OUT,
  output logic            VALID_OUT
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] holdData_q, holdData_d;
  logic            holdValid_q, holdValid_d;
  logic [XLEN-1:0] redirectPc_q, redirectPc_d;

  logic [XLEN-1:0] pcPlus4;
  logic [XLEN-1:0] branchTarget;
  logic            accept;

  logic            ifidLoad;
  logic            ifidFlush;
  logic            ifidHold;
  logic [XLEN-1:0] ifidInstr;

  // The address only moves on accepts or redirects, so it stays put while busy.
  // The read request comes straight from the state, so reset drops it at once.
  assign IMEM_READ    = (state_q == FETCH) || (state_q == DRAIN);
  assign IMEM_ADDR    = pc_q;
  assign accept       = IMEM_READ && !IMEM_BUSYWAIT;
  assign pcPlus4      = pc_q + XLEN'(4);
  assign branchTarget = wordAlign(BRANCH_TARGET);

  // Next-state, PC, hold-buffer and IF/ID control; a redirect overrides everything
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    holdData_d   = holdData_q;
    holdValid_d  = holdValid_q;
    redirectPc_d = redirectPc_q;
    ifidLoad     = 1'b0;
    ifidFlush    = 1'b0;
    ifidHold     = STALL;
    ifidInstr    = IMEM_READDATA;

    if (BRANCH_TAKEN) begin
      ifidFlush   = 1'b1;
      holdValid_d = 1'b0;
      if (IMEM_READ && IMEM_BUSYWAIT) begin
        redirectPc_d = branchTarget;
        state_d      = DRAIN;
      end else begin
        pc_d    = branchTarget;
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        START: begin
          ifidHold = 1'b1;
          state_d  = FETCH;
        end
        FETCH: begin
          if (accept) begin
            if (STALL) begin
              holdData_d  = IMEM_READDATA;
              holdValid_d = 1'b1;
              state_d     = HOLD;
            end else begin
              ifidLoad = 1'b1;
              pc_d     = pcPlus4;
            end
          end
        end
        HOLD: begin
          if (!STALL) begin
            ifidLoad    = holdValid_q;
            ifidInstr   = holdData_q;
            holdValid_d = 1'b0;
            pc_d        = pcPlus4;
            state_d     = FETCH;
          end
        end
        DRAIN: begin
          if (accept) begin
            pc_d    = redirectPc_q;
            state_d = FETCH;
          end
        end
        default: begin
          state_d = START;
        end
      endcase
    end
  end

  // Fetch-side state registers, cleared asynchronously so an access is abandoned
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= START;
      pc_q         <= RESET_PC;
      holdData_q   <= '0;
      holdValid_q  <= 1'b0;
      redirectPc_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      holdData_q   <= holdData_d;
      holdValid_q  <= holdValid_d;
      redirectPc_q <= redirectPc_d;
    end
  end

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifIdRegister (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .load_i    (ifidLoad),
    .flush_i   (ifidFlush),
    .hold_i    (ifidHold),
    .instr_i   (ifidInstr),
    .pc_i      (pc_q),
    .pcPlus4_i (pcPlus4),
    .instr_o   (INSTRUCTION),
    .pc_o      (PC_OUT),
    .pcPlus4_o (PC_PLUS4_OUT),
    .valid_o   (VALID_OUT)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for the fetch unit: a zero/variable-wait memory model, a
// scoreboard of instructions expected to issue, and directed checks on the
// handshake, stalls, redirects, PC wrap and asynchronous reset.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        STALL = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = 32'h0;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic [31:0] IMEM_READDATA;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READ;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_OUT;
  logic [31:0] PC_PLUS4_OUT;
  logic        VALID_OUT;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
  } expEntry_t;

  expEntry_t sbQueue[$];
  expEntry_t monEntry;
  logic      stallAtEdge;

  instruction_fetch_unit dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .STALL         (STALL),
    .BRANCH_TAKEN  (BRANCH_TAKEN),
    .BRANCH_TARGET (BRANCH_TARGET),
    .IMEM_ADDR     (IMEM_ADDR),
    .IMEM_READ     (IMEM_READ),
    .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
    .IMEM_READDATA (IMEM_READDATA),
    .INSTRUCTION   (INSTRUCTION),
    .PC_OUT        (PC_OUT),
    .PC_PLUS4_OUT  (PC_PLUS4_OUT),
    .VALID_OUT     (VALID_OUT)
  );

  // Each memory word is derived from its own address
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return addr ^ 32'hA5C3_0000;
  endfunction

  always #5 CLK = ~CLK;

  // Memory model: the word at the presented address is always on the bus
  always_comb begin
    IMEM_READDATA = 32'h0;
    IMEM_READDATA = memWord(IMEM_ADDR);
  end

  // Remember whether the last edge was stalled (a stalled edge never issues)
  always @(posedge CLK) stallAtEdge <= STALL;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic pushExpected(input logic [31:0] addr);
    expEntry_t e;
    e.instr   = memWord(addr);
    e.pc      = addr;
    e.pcPlus4 = addr + 32'd4;
    sbQueue.push_back(e);
  endtask

  task automatic applyStimulus(input logic stall, input logic br,
                               input logic [31:0] target, input logic busy);
    @(negedge CLK);
    STALL         = stall;
    BRANCH_TAKEN  = br;
    BRANCH_TARGET = target;
    IMEM_BUSYWAIT = busy;
  endtask

  // Scoreboard: every freshly issued instruction must be the next one expected
  always @(negedge CLK) begin
    if (VALID_OUT === 1'b1 && stallAtEdge === 1'b0) begin
      compared++;
      assert (sbQueue.size() > 0)
      else begin
        mismatched++;
        $error("[TB] FAIL sbUnexpected: observed issue of pc %h expected none", PC_OUT);
      end
      if (sbQueue.size() > 0) begin
        monEntry = sbQueue.pop_front();
        checkOutput("sbInstr", INSTRUCTION, monEntry.instr);
        checkOutput("sbPc", PC_OUT, monEntry.pc);
        checkOutput("sbPcPlus4", PC_PLUS4_OUT, monEntry.pcPlus4);
      end
    end
  end

  initial begin
    repeat (2) @(negedge CLK);

    // Reset values
    checkOutput("rstInstr", INSTRUCTION, NOP);
    checkOutput("rstPcOut", PC_OUT, 32'h0);
    checkOutput("rstPcPlus4", PC_PLUS4_OUT, 32'h0);
    checkOutput("rstValid", 32'(VALID_OUT), 32'h0);
    checkOutput("rstRead", 32'(IMEM_READ), 32'h0);
    checkOutput("rstAddr", IMEM_ADDR, 32'h0);

    // Zero-wait streaming from 0
    for (int a = 0; a < 32; a += 4) pushExpected(32'(a));
    RESET = 1'b0;
    checkOutput("startIdle", 32'(IMEM_READ), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("fetchRead", 32'(IMEM_READ), 32'h1);
    checkOutput("addr0", IMEM_ADDR, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("addr4", IMEM_ADDR, 32'h4);

    // Three wait states on address 8
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("busyAddr", IMEM_ADDR, 32'h8);
      if (i > 0) begin
        checkOutput("busyBubbleInstr", INSTRUCTION, NOP);
        checkOutput("busyBubbleValid", 32'(VALID_OUT), 32'h0);
      end
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("busyAddrLast", IMEM_ADDR, 32'h8);
    checkOutput("busyBubbleInstr", INSTRUCTION, NOP);
    checkOutput("busyBubbleValid", 32'(VALID_OUT), 32'h0);

    // Stall for four cycles while the word at 0x10 is accepted
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("addrC", IMEM_ADDR, 32'hC);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("addr10", IMEM_ADDR, 32'h10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("holdRead", 32'(IMEM_READ), 32'h0);
      checkOutput("holdAddr", IMEM_ADDR, 32'h10);
      checkOutput("holdInstr", INSTRUCTION, memWord(32'hC));
      checkOutput("holdPcOut", PC_OUT, 32'hC);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("holdReadLast", 32'(IMEM_READ), 32'h0);
    checkOutput("holdInstrLast", INSTRUCTION, memWord(32'hC));
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("releaseRead", 32'(IMEM_READ), 32'h1);
    checkOutput("addr14", IMEM_ADDR, 32'h14);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("addr18", IMEM_ADDR, 32'h18);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("addr1C", IMEM_ADDR, 32'h1C);

    // Redirect to 0x102 while busy on 0x20: drain, discard, refetch at 0x100
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("addr20", IMEM_ADDR, 32'h20);
    pushExpected(32'h100);
    applyStimulus(1'b0, 1'b1, 32'h102, 1'b1);
    checkOutput("drainAddrA", IMEM_ADDR, 32'h20);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("drainAddrB", IMEM_ADDR, 32'h20);
    checkOutput("drainRead", 32'(IMEM_READ), 32'h1);
    checkOutput("drainValid", 32'(VALID_OUT), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("drainAddrC", IMEM_ADDR, 32'h20);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("targetAddr", IMEM_ADDR, 32'h100);
    checkOutput("targetValid", 32'(VALID_OUT), 32'h0);
    pushExpected(32'h104);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("addr104", IMEM_ADDR, 32'h104);

    // Redirect together with stall while a word sits in the hold buffer
    pushExpected(32'h200);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("addr108", IMEM_ADDR, 32'h108);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b0);
    checkOutput("holdRead2", 32'(IMEM_READ), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("flushInstr", INSTRUCTION, NOP);
    checkOutput("flushValid", 32'(VALID_OUT), 32'h0);
    checkOutput("addr200", IMEM_ADDR, 32'h200);
    checkOutput("addr200Read", 32'(IMEM_READ), 32'h1);

    // Redirect to an unaligned top-of-memory target and wrap PC+4
    pushExpected(32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    pushExpected(32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("addrTop", IMEM_ADDR, 32'hFFFF_FFFC);
    checkOutput("topFlushValid", 32'(VALID_OUT), 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("wrapPcOut", PC_OUT, 32'hFFFF_FFFC);
    checkOutput("wrapPcPlus4", PC_PLUS4_OUT, 32'h0);
    checkOutput("wrapAddr", IMEM_ADDR, 32'h0);

    // Reset in the middle of a busy access
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("preRstAddr", IMEM_ADDR, 32'h4);
    checkOutput("preRstRead", 32'(IMEM_READ), 32'h1);
    checkOutput("preRstPcPlus4", PC_PLUS4_OUT, 32'h4);
    #2 RESET = 1'b1;
    #1;
    checkOutput("midRstRead", 32'(IMEM_READ), 32'h0);
    checkOutput("midRstAddr", IMEM_ADDR, 32'h0);
    checkOutput("midRstInstr", INSTRUCTION, NOP);
    checkOutput("midRstPcOut", PC_OUT, 32'h0);
    checkOutput("midRstPcPlus4", PC_PLUS4_OUT, 32'h0);
    checkOutput("midRstValid", 32'(VALID_OUT), 32'h0);

    @(negedge CLK);
    checkOutput("sbDrained", 32'(sbQueue.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front stage of the RV32IM pipeline: holds the PC, fetches from instruction memory using the codebase's READ/BUSYWAIT handshake, and owns the IF/ID pipeline register.
- Its INSTRUCTION output feeds the decode stage: the immediate generator, register file addressing and control unit.
- Handles hazard-unit stalls, branch/jump redirects and instruction-memory wait states without losing or duplicating instructions.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble instruction (ADDI x0,x0,0) inserted on flush or empty slot.

Ports:
- CLK  in  1  clock, rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- STALL  in  1  hazard unit: hold the IF/ID register and PC.
- BRANCH_TAKEN  in  1  execute stage: redirect and flush.
- BRANCH_TARGET  in  32  redirect address.
- IMEM_ADDR  out  32  fetch address.
- IMEM_READ  out  1  fetch request.
- IMEM_BUSYWAIT  in  1  memory not ready.
- IMEM_READDATA  in  32  fetched word.
- INSTRUCTION  out  32  IF/ID instruction.
- PC_OUT  out  32  IF/ID PC of INSTRUCTION.
- PC_PLUS4_OUT  out  32  IF/ID PC_OUT+4.
- VALID_OUT  out  1  IF/ID slot holds a real instruction.

Behaviour:
- Clock and reset: one clock (CLK); RESET is asynchronous and active-high.
- Reset values:
  - PC=RESET_PC; state=START.
  - INSTRUCTION=NOP_INSTR; PC_OUT=0; PC_PLUS4_OUT=0; VALID_OUT=0.
  - Hold buffer empty; REDIRECT_PC=0.
  - IMEM_READ=0 while RESET is high and in START.
- States:
  - START: one cycle after reset deassertion, then go to FETCH.
  - FETCH: IMEM_READ=1, IMEM_ADDR=PC.
  - HOLD: word accepted while STALL was high; IMEM_READ=0.
  - DRAIN: redirect arrived while memory was busy; IMEM_READ=1, IMEM_ADDR=old PC; data will be discarded.
- Handshake:
  - A word is accepted on the cycle where IMEM_READ=1 and IMEM_BUSYWAIT=0.
  - IMEM_ADDR must not change while IMEM_BUSYWAIT=1.
- FETCH, accept, !STALL, !BRANCH_TAKEN:
  - IF/ID loads {IMEM_READDATA, PC, PC+4, VALID=1}; PC<=PC+4.
  - Throughput is 1 instruction/cycle on zero-wait memory.
- FETCH, accept, STALL: word goes to the hold buffer; PC unchanged; IF/ID unchanged; go to HOLD.
- FETCH, no accept:
  - !STALL: IF/ID loads {NOP_INSTR, PC_OUT unchanged, VALID=0} (bubble).
  - STALL: IF/ID holds.
- HOLD:
  - While STALL=1, remain in HOLD.
  - When STALL=0: IF/ID loads the buffer with VALID=1; PC<=PC+4; go to FETCH.
- BRANCH_TAKEN has highest priority, over STALL and over an accept in the same cycle:
  - IF/ID loads NOP_INSTR with VALID=0.
  - Any hold-buffer content is dropped.
  - Target address is {BRANCH_TARGET[31:2],2'b00}.
  - If IMEM_READ=1 and IMEM_BUSYWAIT=1: REDIRECT_PC<=target; go to DRAIN.
  - Otherwise: PC<=target; go to FETCH.
- DRAIN:
  - On accept: discard the word; PC<=REDIRECT_PC; go to FETCH.
  - A new BRANCH_TAKEN in DRAIN overwrites REDIRECT_PC.
  - IF/ID shows a bubble, or holds if STALL=1.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0), with no flag.
- Reset mid-operation: all state is cleared immediately; an outstanding memory access is abandoned; IMEM_READ drops asynchronously.
- Latency: from address presented to VALID_OUT is 1 + wait cycles. A redirect's first valid instruction appears 2 cycles after BRANCH_TAKEN on zero-wait memory.

Decomposition:
- Shared package (rv32_pipeline_pkg):
  - NOP_INSTR and RESET_PC constants.
  - fetch state enum {START, FETCH, HOLD, DRAIN}.
  - XLEN=32.
- One natural sub-module: if_id_register.
  - Async-reset register for {INSTRUCTION, PC_OUT, PC_PLUS4_OUT, VALID_OUT}.
  - Controls: load, flush and hold; flush has priority over hold.
- PC, FSM and hold buffer stay in instruction_fetch_unit.

Test Plan:
- Reset, zero-wait memory returning addr-derived words, STALL=0 -> IMEM_ADDR 0,4,8,...; from 2nd cycle VALID_OUT=1 with PC_OUT 0,4,8; PC_PLUS4_OUT=PC_OUT+4.
- IMEM_BUSYWAIT high 3 cycles on addr 8 -> IMEM_ADDR stays 8; 3 bubble cycles with INSTRUCTION=32'h00000013, VALID_OUT=0; then the word at 8 appears once.
- STALL high 4 cycles while a word at 0x10 is accepted -> IF/ID frozen, PC stays 0x10, IMEM_READ=0 in HOLD; after release, 0x10 appears exactly once, then 0x14.
- BRANCH_TAKEN with target 0x102 while busy on 0x20 -> IMEM_ADDR held at 0x20 until BUSYWAIT drops; that word is never issued; next fetch is 0x100; no VALID_OUT for 0x20.
- BRANCH_TAKEN and STALL together with a word in HOLD -> buffer dropped; IF/ID=NOP, VALID_OUT=0; next fetch is the target.
- PC=32'hFFFFFFFC fetch; also RESET asserted mid-busywait -> PC_PLUS4_OUT=0; on reset all outputs return to reset values immediately and IMEM_READ=0.
